// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } ifu_state_t;

  typedef enum logic [1:0] {
    SEL_SEQ     = 2'd0,
    SEL_BRANCH  = 2'd1,
    SEL_LATCHED = 2'd2
  } addr_sel_t;

  // A fetched word together with the byte address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word;
  } fetch_word_t;

endpackage

// File: rtl/fetch_addr_mux.sv
// Next fetch address selection: sequential step, live branch target or the
// target latched while a stale request drains.
module fetch_addr_mux
  import ifu_pkg::*;
#(
  parameter int unsigned PC_STEP = 4
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_branch_target,
  input  logic [XLEN-1:0] i_latched_target,
  input  addr_sel_t       i_sel,
  output logic [XLEN-1:0] o_next_addr_c
);

  // Sequential addition wraps naturally at 2^32.
  always_comb begin
    o_next_addr_c = i_pc + XLEN'(PC_STEP);
    case (i_sel)
      SEL_BRANCH:  o_next_addr_c = i_branch_target;
      SEL_LATCHED: o_next_addr_c = i_latched_target;
      default:     o_next_addr_c = i_pc + XLEN'(PC_STEP);
    endcase
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Single-outstanding-request instruction fetcher with a one-word hold
// buffer and branch redirect, including redirect while a request is in flight.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        Clk,
  input  logic        Clr,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target
);

  ifu_state_t      r_state;
  ifu_state_t      w_state_nxt;
  logic            r_mem_req;
  logic            w_mem_req_nxt;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] w_mem_addr_nxt;
  fetch_word_t     r_word;
  fetch_word_t     w_word_nxt;
  logic            r_instr_valid;
  logic            w_instr_valid_nxt;
  logic [XLEN-1:0] r_target;
  logic [XLEN-1:0] w_target_nxt;
  addr_sel_t       w_sel;
  logic [XLEN-1:0] w_next_addr;

  // A live branch always wins; otherwise DISCARD resumes at the latched target.
  always_comb begin
    w_sel = SEL_SEQ;
    if (branch_taken) begin
      w_sel = SEL_BRANCH;
    end else if (r_state == DISCARD) begin
      w_sel = SEL_LATCHED;
    end
  end

  fetch_addr_mux #(
    .PC_STEP (PC_STEP)
  ) u_fetch_addr_mux (
    .i_pc             (r_word.pc),
    .i_branch_target  (branch_target),
    .i_latched_target (r_target),
    .i_sel            (w_sel),
    .o_next_addr_c    (w_next_addr)
  );

  always_ff @(posedge Clk) begin
    if (Clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_mem_req_nxt     = r_mem_req;
    w_mem_addr_nxt    = r_mem_addr;
    w_word_nxt        = r_word;
    w_instr_valid_nxt = r_instr_valid;
    w_target_nxt      = r_target;
    case (r_state)
      IDLE: begin
        w_state_nxt       = REQ;
        w_mem_req_nxt     = 1'b1;
        w_mem_addr_nxt    = RESET_PC;
        w_instr_valid_nxt = 1'b0;
      end
      REQ: begin
        if (branch_taken && mem_ack) begin
          // Returned word belongs to the abandoned path; reissue at the target.
          w_mem_req_nxt  = 1'b1;
          w_mem_addr_nxt = w_next_addr;
        end else if (branch_taken) begin
          w_target_nxt = branch_target;
          w_state_nxt  = DISCARD;
        end else if (mem_ack) begin
          w_word_nxt.pc     = r_mem_addr;
          w_word_nxt.word   = mem_rdata;
          w_instr_valid_nxt = 1'b1;
          w_mem_req_nxt     = 1'b0;
          w_state_nxt       = HOLD;
        end
      end
      HOLD: begin
        if (branch_taken || instr_ready) begin
          w_instr_valid_nxt = 1'b0;
          w_mem_req_nxt     = 1'b1;
          w_mem_addr_nxt    = w_next_addr;
          w_state_nxt       = REQ;
        end
      end
      DISCARD: begin
        if (branch_taken) begin
          w_target_nxt = branch_target;
        end
        if (mem_ack) begin
          w_mem_req_nxt  = 1'b1;
          w_mem_addr_nxt = w_next_addr;
          w_state_nxt    = REQ;
        end
      end
      default: begin
        w_state_nxt       = IDLE;
        w_mem_req_nxt     = 1'b0;
        w_instr_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      r_mem_req     <= 1'b0;
      r_mem_addr    <= RESET_PC;
      r_word        <= '{pc: RESET_PC, word: NOP_WORD};
      r_instr_valid <= 1'b0;
      r_target      <= RESET_PC;
    end else begin
      r_mem_req     <= w_mem_req_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_word        <= w_word_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_target      <= w_target_nxt;
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign instruction = r_word.word;
  assign pc          = r_word.pc;
  assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scenario bench for instruction_fetch_unit with a behavioural memory and a
// stream-level model of which words the datapath should receive.
module tb_instruction_fetch_unit;

  logic        Clk = 1'b0;
  logic        Clr = 1'b1;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] pc;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;

  int total = 0;
  int bad   = 0;

  int mem_lat  = 1;
  bit mem_auto = 1'b1;
  bit junk_en  = 1'b0;
  int cnt      = 0;
  int lat_cur  = 1;

  instruction_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .Clk           (Clk),
    .Clr           (Clr),
    .mem_addr      (mem_addr),
    .mem_req       (mem_req),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .pc            (pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h03B0_1001;
      32'h0000_0004: return 32'h03B0_10AA;
      32'h0000_0008: return 32'h03B0_A0BA;
      32'h0000_000C: return 32'h03B0_A0FF;
      default:       return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Memory: acks each request after lat_cur cycles; may toss junk acks when idle.
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (mem_auto) begin
        if (mem_req) begin
          if (cnt == 0) lat_cur = (mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat;
          cnt++;
          if (cnt >= lat_cur) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_word(mem_addr);
            cnt       = 0;
          end else begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
          end
        end else begin
          cnt       = 0;
          mem_ack   = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
          mem_rdata = $urandom;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_valid(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (instr_valid) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
    ok = instr_valid;
  endtask

  task automatic test_reset();
    Clr = 1'b1;
    tick();
    tick();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr: got %h want 00000000", mem_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    total++; if (instruction !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 00000000", instruction); end
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 00000000", pc); end
  endtask

  task automatic test_first_fetch();
    Clr = 1'b0;
    tick();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin bad++; $display("FAIL first_req: got req=%b addr=%h want req=1 addr=00000000", mem_req, mem_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL first_valid_early: got %b want 0", instr_valid); end
    tick();
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL first_valid: got %b want 1", instr_valid); end
    total++; if (instruction !== 32'h03B0_1001 || pc !== 32'h0) begin bad++; $display("FAIL first_word: got instr=%h pc=%h want 03b01001/00000000", instruction, pc); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL first_req_drop: got %b want 0", mem_req); end
  endtask

  task automatic test_stall();
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (instruction !== 32'h03B0_1001 || pc !== 32'h0 || instr_valid !== 1'b1 || mem_req !== 1'b0) begin
        bad++;
        $display("FAIL stall_c%0d: got instr=%h pc=%h valid=%b req=%b want 03b01001/00000000/1/0", i, instruction, pc, instr_valid, mem_req);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h03B0_1001;
    exp_w[1] = 32'h03B0_10AA;
    exp_w[2] = 32'h03B0_A0BA;
    exp_w[3] = 32'h03B0_A0FF;
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (instr_valid !== 1'b1 || pc !== 32'(k * 4) || instruction !== exp_w[k]) begin
        bad++;
        $display("FAIL b2b_word%0d: got valid=%b pc=%h instr=%h want 1/%h/%h", k, instr_valid, pc, instruction, 32'(k * 4), exp_w[k]);
      end
      if (k == 3) begin
        instr_ready = 1'b0;
        break;
      end
      tick();
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 32'((k + 1) * 4) || instr_valid !== 1'b0) begin
        bad++;
        $display("FAIL b2b_addr%0d: got req=%b addr=%h valid=%b want 1/%h/0", k + 1, mem_req, mem_addr, instr_valid, 32'((k + 1) * 4));
      end
      tick();
    end
    tick();
    total++; if (instr_valid !== 1'b1 || pc !== 32'hC) begin bad++; $display("FAIL b2b_hold_last: got valid=%b pc=%h want 1/0000000c", instr_valid, pc); end
  endtask

  task automatic test_branch_req();
    bit ok;
    mem_lat = 3;
    tick();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin bad++; $display("FAIL brreq_issue: got req=%b addr=%h want 1/00000010", mem_req, mem_addr); end
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    tick();
    branch_taken = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h10 || instr_valid !== 1'b0) begin bad++; $display("FAIL brreq_hold_addr: got req=%b addr=%h valid=%b want 1/00000010/0", mem_req, mem_addr, instr_valid); end
    tick();
    total++; if (mem_addr !== 32'h10 || instr_valid !== 1'b0) begin bad++; $display("FAIL brreq_wait_ack: got addr=%h valid=%b want 00000010/0", mem_addr, instr_valid); end
    tick();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || instr_valid !== 1'b0) begin bad++; $display("FAIL brreq_redirect: got req=%b addr=%h valid=%b want 1/00000100/0", mem_req, mem_addr, instr_valid); end
    wait_valid(12, ok);
    total++; if (!ok || pc !== 32'h100 || instruction !== mem_word(32'h100)) begin bad++; $display("FAIL brreq_word: got valid=%b pc=%h instr=%h want 1/00000100/%h", instr_valid, pc, instruction, mem_word(32'h100)); end
    mem_lat = 1;
    tick();
  endtask

  task automatic test_branch_hold();
    bit ok;
    instr_ready   = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    tick();
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    total++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h40) begin bad++; $display("FAIL brhold_redirect: got valid=%b req=%b addr=%h want 0/1/00000040", instr_valid, mem_req, mem_addr); end
    wait_valid(10, ok);
    total++; if (!ok || pc !== 32'h40 || instruction !== mem_word(32'h40)) begin bad++; $display("FAIL brhold_word: got valid=%b pc=%h instr=%h want 1/00000040/%h", instr_valid, pc, instruction, mem_word(32'h40)); end
  endtask

  task automatic test_branch_ack();
    bit ok;
    instr_ready = 1'b1;
    tick();
    instr_ready   = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 32'h200;
    tick();
    branch_taken = 1'b0;
    total++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h200) begin bad++; $display("FAIL brack_redirect: got valid=%b req=%b addr=%h want 0/1/00000200", instr_valid, mem_req, mem_addr); end
    wait_valid(10, ok);
    total++; if (!ok || pc !== 32'h200 || instruction !== mem_word(32'h200)) begin bad++; $display("FAIL brack_word: got valid=%b pc=%h instr=%h want 1/00000200/%h", instr_valid, pc, instruction, mem_word(32'h200)); end
  endtask

  task automatic test_clr_mid_req();
    bit ok;
    mem_lat = 3;
    tick();
    branch_taken  = 1'b1;
    branch_target = 32'h8;
    tick();
    branch_taken = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin bad++; $display("FAIL clr_pre: got req=%b addr=%h want 1/00000008", mem_req, mem_addr); end
    Clr       = 1'b1;
    mem_auto  = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    mem_lat   = 1;
    tick();
    total++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || instr_valid !== 1'b0 || pc !== 32'h0 || instruction !== 32'h0) begin
      bad++; $display("FAIL clr_state: got req=%b addr=%h valid=%b pc=%h instr=%h want 0/00000000/0/00000000/00000000", mem_req, mem_addr, instr_valid, pc, instruction);
    end
    tick();
    Clr = 1'b0;
    tick();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0 || instr_valid !== 1'b0) begin bad++; $display("FAIL clr_refetch: got req=%b addr=%h valid=%b want 1/00000000/0", mem_req, mem_addr, instr_valid); end
    mem_ack = 1'b0;
    tick();
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL clr_stale_ack: got valid=%b want 0", instr_valid); end
    mem_auto = 1'b1;
    wait_valid(10, ok);
    total++; if (!ok || pc !== 32'h0 || instruction !== 32'h03B0_1001) begin bad++; $display("FAIL clr_word: got valid=%b pc=%h instr=%h want 1/00000000/03b01001", instr_valid, pc, instruction); end
  endtask

  // Stream model: consumed words run sequentially from the last redirect.
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    bit          br;
    bit          rdy;
    int          consumed;
    exp_pc   = pc;
    consumed = 0;
    mem_lat  = 0;
    junk_en  = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      br  = ($urandom_range(0, 15) == 0);
      rdy = 1'($urandom_range(0, 1));
      tgt = $urandom;
      tgt[1:0] = 2'b00;
      if ($urandom_range(0, 5) == 0) tgt = 32'hFFFF_FFF4;
      total++;
      if (mem_req === 1'b1 && instr_valid === 1'b1) begin
        bad++; $display("FAIL rand_valid_during_req: cycle %0d req=%b valid=%b want not both", i, mem_req, instr_valid);
      end
      if (instr_valid && rdy && !br) begin
        total++;
        if (pc !== exp_pc || instruction !== mem_word(exp_pc)) begin
          bad++;
          $display("FAIL rand_word: cycle %0d got pc=%h instr=%h want %h/%h", i, pc, instruction, exp_pc, mem_word(exp_pc));
        end
        consumed++;
        exp_pc = pc + 32'd4;
      end
      if (br) exp_pc = tgt;
      instr_ready   = rdy;
      branch_taken  = br;
      branch_target = tgt;
      tick();
    end
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    junk_en      = 1'b0;
    total++; if (consumed < 100) begin bad++; $display("FAIL rand_progress: got %0d words want >= 100", consumed); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_back_to_back();
    test_branch_req();
    test_branch_hold();
    test_branch_ack();
    test_clr_mid_req();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the byte address of the first fetch after reset.
REQ-002 SHALL have parameter PC_STEP, default 4, meaning the byte increment between sequential fetches.
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Clr, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port mem_addr, output, 32 bits: fetch byte address to the instruction memory.
REQ-006 SHALL have port mem_req, output, 1 bit: fetch request, held until acknowledged.
REQ-007 SHALL have port mem_ack, input, 1 bit: memory has placed data on mem_rdata this cycle.
REQ-008 SHALL have port mem_rdata, input, 32 bits: instruction word returned by memory.
REQ-009 SHALL have port instruction, output, 32 bits: instruction word presented to the datapath.
REQ-010 SHALL have port instr_valid, output, 1 bit: the instruction output holds a live word.
REQ-011 SHALL have port instr_ready, input, 1 bit: the datapath consumes the instruction this cycle.
REQ-012 SHALL have port pc, output, 32 bits: address of the word currently on instruction.
REQ-013 SHALL have port branch_taken, input, 1 bit: redirect request from the datapath.
REQ-014 SHALL have port branch_target, input, 32 bits: redirect byte address, sampled when branch_taken is high.

Function
REQ-015 SHALL implement a state machine with states IDLE, REQ, HOLD, DISCARD.
REQ-016 SHALL go IDLE->REQ unconditionally on the first edge with Clr low; mem_addr = RESET_PC.
REQ-017 SHALL, in REQ, drive mem_req=1 with mem_addr stable until the edge where mem_ack=1.
REQ-018 SHALL, on REQ with mem_ack=1 and no branch, load instruction<=mem_rdata and pc<=mem_addr, then enter HOLD with instr_valid=1 from the next cycle (one-cycle latency from ack).
REQ-019 SHALL, in HOLD, keep instruction, pc and instr_valid stable while instr_ready=0.
REQ-020 SHALL, in HOLD with instr_ready=1, clear instr_valid and enter REQ with mem_addr=pc+PC_STEP, so mem_req is asserted the next cycle.
REQ-021 SHALL, in HOLD with branch_taken=1, drop the held word (instr_valid=0) and enter REQ with mem_addr=branch_target; branch wins over a simultaneous instr_ready.
REQ-022 SHALL, in REQ with branch_taken=1 and mem_ack=0, latch branch_target and enter DISCARD, keeping mem_req=1 and the old mem_addr until ack.
REQ-023 SHALL, in REQ with branch_taken=1 and mem_ack=1 in the same cycle, discard mem_rdata and enter REQ with mem_addr=branch_target.
REQ-024 SHALL, in DISCARD, ignore mem_rdata on mem_ack and then enter REQ with the latched target; a further branch_taken in DISCARD replaces the latched target.
REQ-025 SHALL compute address arithmetic modulo 2^32 (32'hFFFFFFFC+4 wraps to 32'h00000000).
REQ-026 SHALL never assert instr_valid in IDLE, REQ or DISCARD.
REQ-027 SHALL ignore mem_ack while mem_req=0.

Reset
REQ-028 SHALL, on any edge with Clr=1 and in any state, force state=IDLE, mem_req=0, mem_addr=RESET_PC, instruction=0, instr_valid=0, pc=RESET_PC, and clear the latched target.
REQ-029 SHALL abandon any in-flight request on reset mid-REQ; a mem_ack arriving during or after reset is ignored until a new mem_req is issued.

Structure
REQ-030 SHALL take state encodings (IDLE, REQ, HOLD, DISCARD) and the NOP word 32'h00000000 from a shared package, ifu_pkg.
REQ-031 SHALL be a single module; the next-address mux (pc+PC_STEP / branch_target / latched target) is the natural sub-module, fetch_addr_mux.

Verification
REQ-032 SHALL cover reset then memory with 1-cycle ack returning 32'h03B01001: mem_addr=0, instruction=32'h03B01001, pc=0, instr_valid one cycle after ack.
REQ-033 SHALL cover back-to-back accept of 32'h03B01001, 32'h03B010AA, 32'h03B0A0BA, 32'h03B0A0FF with instr_ready=1: mem_addr sequence 0,4,8,C and pc follows.
REQ-034 SHALL cover stall: instr_ready=0 for 5 cycles in HOLD: instruction and pc unchanged, mem_req=0 throughout.
REQ-035 SHALL cover branch in REQ with a 3-cycle ack latency, target 32'h00000100: the late word is discarded, next mem_addr=32'h100, and the next valid pc=32'h100.
REQ-036 SHALL cover a simultaneous branch_taken and instr_ready in HOLD, target 32'h40: the held word is dropped and the next mem_addr=32'h40.
REQ-037 SHALL cover Clr asserted mid-REQ at mem_addr=8: the next fetch after release is from RESET_PC, and a stale ack does not produce instr_valid.
